// File: rtl/natalius_pc_pkg.sv
// natalius_pc_pkg: shared op codes, widths and sequencer state encodings
package natalius_pc_pkg;
  localparam int PC_W = 11;
  localparam int STACK_DEPTH = 15;
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP = 3'd1;
  localparam logic [2:0] OP_JZ = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET = 3'd4;
  localparam logic [2:0] OP_RETI = 3'd5;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RET_WAIT = 1'b1;
endpackage

// File: rtl/pc_call_sequencer.sv
// pc_call_sequencer: pc sequencer with mirrored return-stack depth; PC_IRQ_EN adds irq entry and RETI
module pc_call_sequencer #(
  parameter int PC_W = natalius_pc_pkg::PC_W,
  parameter int STACK_DEPTH = natalius_pc_pkg::STACK_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(11'h7F0)
) (
  input  logic            clk,
  input  logic            rst,
`ifdef PC_IRQ_EN
  input  logic            irq,
`endif
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [PC_W-1:0] op_target,
  input  logic            zero_flag,
  output logic [PC_W-1:0] pc,
  output logic            stk_wr_en,
  output logic            stk_rd_en,
  output logic [PC_W-1:0] stk_din,
  input  logic [PC_W-1:0] stk_dout,
  output logic [3:0]      depth,
  output logic            stk_ovf,
  output logic            stk_unf
);
  import natalius_pc_pkg::*;
  logic [0:0] state;
  logic acc, irq_take, reti_op, call_req, ret_req, full, empty;
  logic [PC_W-1:0] pc_inc, pc_nxt;
`ifdef PC_IRQ_EN
  logic ie, reti_q;
  assign irq_take = (state == ST_IDLE) & irq & ie & !op_valid;
  assign reti_op = op_code == OP_RETI;
`else
  assign irq_take = 1'b0;
  assign reti_op = 1'b0;
`endif
  // Accept decode, stack strobes and next-pc selection
  always_comb begin
    op_ready = state == ST_IDLE;
    acc = op_valid & op_ready;
    full = depth == 4'(STACK_DEPTH);
    empty = depth == 4'd0;
    call_req = acc & (op_code == OP_CALL) | irq_take;
    ret_req = acc & ((op_code == OP_RET) | reti_op);
    pc_inc = pc + 1'b1;
    stk_wr_en = call_req & !full;
    stk_rd_en = ret_req & !empty;
    stk_din = irq_take ? pc : pc_inc;
    pc_nxt = state == ST_RET_WAIT ? stk_dout :
             irq_take ? IRQ_VECTOR :
             !acc ? pc :
             (op_code == OP_JMP) | (op_code == OP_CALL) | ((op_code == OP_JZ) & zero_flag) ? op_target :
             stk_rd_en ? pc : pc_inc;
  end
  // Registered pc, depth mirror, sticky flags and FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      depth <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      state <= ST_IDLE;
    end else begin
      pc <= pc_nxt;
      depth <= depth + {3'b0, stk_wr_en} - {3'b0, stk_rd_en};
      stk_ovf <= stk_ovf | (call_req & full);
      stk_unf <= stk_unf | (ret_req & empty);
      state <= stk_rd_en ? ST_RET_WAIT : ST_IDLE;
    end
  end
`ifdef PC_IRQ_EN
  // Interrupt enable: cleared on entry, restored when RETI completes
  always_ff @(posedge clk) begin
    if (rst) begin
      ie <= 1'b1;
      reti_q <= 1'b0;
    end else begin
      reti_q <= acc & reti_op;
      ie <= irq_take ? 1'b0 : ((state == ST_RET_WAIT) & reti_q) | (acc & reti_op & empty) ? 1'b1 : ie;
    end
  end
`endif
endmodule

// File: tb/tb_pc_call_sequencer.sv
// tb_pc_call_sequencer: directed self-checking bench with a behavioural return stack
module tb_pc_call_sequencer;
  logic clk = 0, rst = 1, op_valid = 0, zero_flag = 0, irq = 0;
  logic [2:0] op_code = 0;
  logic [10:0] op_target = 0, pc, stk_din, stk_dout;
  logic op_ready, stk_wr_en, stk_rd_en, stk_ovf, stk_unf;
  logic [3:0] depth;
  int total = 0, bad = 0;
  logic [10:0] mem [16];
  int sp;
  logic [10:0] exp_push [15];

  pc_call_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef PC_IRQ_EN
    .irq(irq),
`endif
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_target(op_target),
    .zero_flag(zero_flag), .pc(pc), .stk_wr_en(stk_wr_en), .stk_rd_en(stk_rd_en),
    .stk_din(stk_din), .stk_dout(stk_dout), .depth(depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (stk_wr_en) begin
      mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_rd_en) begin
      stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [10:0] t, input logic z);
    op_valid = 1; op_code = c; op_target = t; zero_flag = z;
    #1;
  endtask

  task automatic idle();
    op_valid = 0; op_code = 0; op_target = 0; zero_flag = 0;
  endtask

  task automatic do_reset();
    idle(); irq = 0; rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pc !== 11'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", pc); end
    total++; if (depth !== 4'd0 || stk_ovf !== 0 || stk_unf !== 0) begin bad++; $display("FAIL reset_state depth=%0d ovf=%b unf=%b exp 0/0/0", depth, stk_ovf, stk_unf); end
    total++; if (op_ready !== 1 || stk_wr_en !== 0 || stk_rd_en !== 0) begin bad++; $display("FAIL reset_strobes rdy=%b wr=%b rd=%b exp 1/0/0", op_ready, stk_wr_en, stk_rd_en); end
  endtask

  task automatic test_next();
    for (int i = 1; i <= 3; i++) begin
      drive(3'd0, 11'h000, 0);
      total++; if (stk_wr_en !== 0 || stk_rd_en !== 0) begin bad++; $display("FAIL next_strobes wr=%b rd=%b exp 0/0", stk_wr_en, stk_rd_en); end
      tick();
      total++; if (pc !== 11'(i)) begin bad++; $display("FAIL next_pc got=%h exp=%h", pc, 11'(i)); end
    end
    idle(); tick();
    total++; if (pc !== 11'h003) begin bad++; $display("FAIL idle_hold got=%h exp=003", pc); end
  endtask

  task automatic test_wrap_jz();
    drive(3'd1, 11'h7FF, 0); tick();
    total++; if (pc !== 11'h7FF) begin bad++; $display("FAIL jmp got=%h exp=7ff", pc); end
    drive(3'd0, 11'h000, 0); tick();
    total++; if (pc !== 11'h000) begin bad++; $display("FAIL wrap got=%h exp=000", pc); end
    drive(3'd2, 11'h123, 0); tick();
    total++; if (pc !== 11'h001) begin bad++; $display("FAIL jz_not_taken got=%h exp=001", pc); end
    drive(3'd2, 11'h123, 1); tick();
    total++; if (pc !== 11'h123) begin bad++; $display("FAIL jz_taken got=%h exp=123", pc); end
    drive(3'd7, 11'h555, 1); tick();
    total++; if (pc !== 11'h124) begin bad++; $display("FAIL op7_next got=%h exp=124", pc); end
`ifndef PC_IRQ_EN
    drive(3'd5, 11'h555, 1); tick();
    total++; if (pc !== 11'h125) begin bad++; $display("FAIL op5_next got=%h exp=125", pc); end
`endif
    idle();
  endtask

  task automatic test_call_ret();
    drive(3'd1, 11'h010, 0); tick();
    drive(3'd3, 11'h200, 0);
    total++; if (stk_wr_en !== 1 || stk_din !== 11'h011 || stk_rd_en !== 0) begin bad++; $display("FAIL call_push wr=%b din=%h rd=%b exp 1/011/0", stk_wr_en, stk_din, stk_rd_en); end
    tick();
    total++; if (pc !== 11'h200 || depth !== 4'd1) begin bad++; $display("FAIL call_pc pc=%h depth=%0d exp 200/1", pc, depth); end
    drive(3'd4, 11'h000, 0);
    total++; if (stk_rd_en !== 1 || stk_wr_en !== 0) begin bad++; $display("FAIL ret_pop rd=%b wr=%b exp 1/0", stk_rd_en, stk_wr_en); end
    tick(); idle(); #1;
    total++; if (op_ready !== 0 || stk_rd_en !== 0 || stk_wr_en !== 0) begin bad++; $display("FAIL ret_wait rdy=%b rd=%b wr=%b exp 0/0/0", op_ready, stk_rd_en, stk_wr_en); end
    tick();
    total++; if (pc !== 11'h011 || depth !== 4'd0 || op_ready !== 1) begin bad++; $display("FAIL ret_done pc=%h depth=%0d rdy=%b exp 011/0/1", pc, depth, op_ready); end
  endtask

  task automatic test_nested();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      exp_push[i] = (i == 0) ? 11'h001 : 11'(11'h100 + 16 * (i - 1) + 1);
      drive(3'd3, 11'(11'h100 + 16 * i), 0);
      total++; if (stk_wr_en !== 1 || stk_din !== exp_push[i]) begin bad++; $display("FAIL nest_push%0d wr=%b din=%h exp 1/%h", i, stk_wr_en, stk_din, exp_push[i]); end
      tick();
    end
    total++; if (depth !== 4'd15 || stk_ovf !== 0) begin bad++; $display("FAIL nest_depth depth=%0d ovf=%b exp 15/0", depth, stk_ovf); end
    drive(3'd3, 11'h7AA, 0);
    total++; if (stk_wr_en !== 0) begin bad++; $display("FAIL ovf_push wr=%b exp 0", stk_wr_en); end
    tick();
    total++; if (stk_ovf !== 1 || pc !== 11'h7AA || depth !== 4'd15) begin bad++; $display("FAIL ovf ovf=%b pc=%h depth=%0d exp 1/7aa/15", stk_ovf, pc, depth); end
    for (int k = 0; k < 15; k++) begin
      drive(3'd4, 11'h000, 0);
      total++; if (stk_rd_en !== 1) begin bad++; $display("FAIL nest_pop%0d rd=%b exp 1", k, stk_rd_en); end
      tick(); idle(); tick();
      total++; if (pc !== exp_push[14-k]) begin bad++; $display("FAIL nest_ret%0d pc=%h exp %h", k, pc, exp_push[14-k]); end
    end
    total++; if (depth !== 4'd0 || stk_ovf !== 1 || stk_unf !== 0) begin bad++; $display("FAIL nest_end depth=%0d ovf=%b unf=%b exp 0/1/0", depth, stk_ovf, stk_unf); end
  endtask

  task automatic test_underflow_rst();
    do_reset();
    drive(3'd4, 11'h000, 0);
    total++; if (stk_rd_en !== 0) begin bad++; $display("FAIL unf_pop rd=%b exp 0", stk_rd_en); end
    tick();
    total++; if (stk_unf !== 1 || pc !== 11'h001 || op_ready !== 1 || depth !== 4'd0) begin bad++; $display("FAIL unf unf=%b pc=%h rdy=%b depth=%0d exp 1/001/1/0", stk_unf, pc, op_ready, depth); end
    drive(3'd3, 11'h055, 0); tick();
    drive(3'd4, 11'h000, 0); tick();
    idle(); rst = 1; #1;
    total++; if (op_ready !== 0) begin bad++; $display("FAIL rst_in_wait_pre rdy=%b exp 0", op_ready); end
    tick(); rst = 0;
    total++; if (pc !== 11'h000 || depth !== 4'd0 || op_ready !== 1 || stk_unf !== 0) begin bad++; $display("FAIL rst_mid_ret pc=%h depth=%0d rdy=%b unf=%b exp 000/0/1/0", pc, depth, op_ready, stk_unf); end
  endtask

`ifdef PC_IRQ_EN
  task automatic test_irq();
    do_reset();
    drive(3'd1, 11'h040, 0); tick();
    idle(); irq = 1; #1;
    total++; if (stk_wr_en !== 1 || stk_din !== 11'h040) begin bad++; $display("FAIL irq_push wr=%b din=%h exp 1/040", stk_wr_en, stk_din); end
    tick();
    total++; if (pc !== 11'h7F0 || depth !== 4'd1) begin bad++; $display("FAIL irq_entry pc=%h depth=%0d exp 7f0/1", pc, depth); end
    total++; if (stk_wr_en !== 0) begin bad++; $display("FAIL irq_masked wr=%b exp 0", stk_wr_en); end
    tick();
    total++; if (pc !== 11'h7F0) begin bad++; $display("FAIL irq_masked_pc pc=%h exp 7f0", pc); end
    irq = 0;
    drive(3'd5, 11'h000, 0);
    total++; if (stk_rd_en !== 1) begin bad++; $display("FAIL reti_pop rd=%b exp 1", stk_rd_en); end
    tick(); idle(); tick();
    total++; if (pc !== 11'h040 || depth !== 4'd0) begin bad++; $display("FAIL reti pc=%h depth=%0d exp 040/0", pc, depth); end
    irq = 1; #1;
    total++; if (stk_wr_en !== 1 || stk_din !== 11'h040) begin bad++; $display("FAIL ie_restored wr=%b din=%h exp 1/040", stk_wr_en, stk_din); end
    irq = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_next();
    test_wrap_jz();
    test_call_ret();
    test_nested();
    test_underflow_rst();
`ifdef PC_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
